trdb_qualif_sync: RTL and testbench

//  Stage directly downstream of trdb_filter. Registers its next-cycle qualification (nc_qualified) into

---
 rtl/trdb_pkg.sv | 13 +
 rtl/trdb_resync_counter.sv | 33 +++
 rtl/trdb_qualif_sync.sv | 109 ++++++++++
 tb/tb_trdb_qualif_sync.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/trdb_pkg.sv
// Shared trace-debugger types and defaults.
// Holds the qualification/resync FSM encoding used by trdb_qualif_sync.
package trdb_pkg;

   localparam int RESYNC_CNT_W_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      TRACING   = 2'd1,
      SYNC_PEND = 2'd2
   } trdb_qsync_state_e;

endpackage

// File: rtl/trdb_resync_counter.sv
// Resync counter: clears, counts qualified retirements, saturates at all-ones,
// and flags when the post-increment value reaches a nonzero period.
module trdb_resync_counter #(
   parameter int W = trdb_pkg::RESYNC_CNT_W_DEFAULT
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clear_i,
   input  logic         enable_i,
   input  logic [W-1:0] max_i,
   output logic [W-1:0] cnt_o,
   output logic         hit_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_inc;

   // Saturating increment: all-ones holds instead of wrapping to zero.
   assign cnt_inc = (cnt_q == {W{1'b1}}) ? cnt_q : cnt_q + W'(1);
   assign hit_o   = (max_i != '0) && (cnt_inc >= max_i);
   assign cnt_o   = cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (enable_i) begin
         cnt_q <= cnt_inc;
      end
   end

endmodule

// File: rtl/trdb_qualif_sync.sv
// Registers next-cycle qualification, decodes start/stop edges and runs the
// resync FSM that requests a sync-support packet every resync_max_i retirements.
module trdb_qualif_sync
   import trdb_pkg::*;
#(
   parameter int RESYNC_CNT_W = RESYNC_CNT_W_DEFAULT
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    trace_enable_i,
   input  logic                    nc_qualified_i,
   input  logic                    valid_i,
   input  logic [RESYNC_CNT_W-1:0] resync_max_i,
   input  logic                    packet_ack_i,
   output logic                    qualified_o,
   output logic                    pc_qualified_o,
   output logic                    first_qualified_o,
   output logic                    unqualified_o,
   output logic                    resync_req_o,
   output logic [RESYNC_CNT_W-1:0] resync_cnt_o,
   output logic [1:0]              state_o
);

   localparam logic [1:0] ST_IDLE      = IDLE;
   localparam logic [1:0] ST_TRACING   = TRACING;
   localparam logic [1:0] ST_SYNC_PEND = SYNC_PEND;

   logic       qualified_q;
   logic       pc_qualified_q;
   logic [1:0] state_q;
   logic [1:0] state_d;
   logic       cnt_clear;
   logic       cnt_en;
   logic       cnt_hit;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         qualified_q    <= 1'b0;
         pc_qualified_q <= 1'b0;
         state_q        <= ST_IDLE;
      end else begin
         qualified_q    <= nc_qualified_i & trace_enable_i;
         pc_qualified_q <= qualified_q;
         state_q        <= state_d;
      end
   end

   assign qualified_o       = qualified_q;
   assign pc_qualified_o    = pc_qualified_q;
   assign first_qualified_o = qualified_q & ~pc_qualified_q;
   assign unqualified_o     = ~qualified_q & pc_qualified_q;

   // Request/ack handshake: resync_req_o stays high from the cycle after the
   // period is reached until the first cycle packet_ack_i is seen with it high;
   // packet_ack_i has no effect while the request is low.
   assign resync_req_o = (state_q == ST_SYNC_PEND);
   assign state_o      = state_q;

   always_comb begin
      state_d   = state_q;
      cnt_clear = 1'b0;
      cnt_en    = 1'b0;
      // Losing qualification wins over ack and increment: the stop packet supersedes resync.
      if (!qualified_q) begin
         state_d   = ST_IDLE;
         cnt_clear = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (first_qualified_o) begin
                  state_d   = ST_TRACING;
                  cnt_clear = 1'b1;
               end
            end
            ST_TRACING: begin
               if (valid_i) begin
                  cnt_en = 1'b1;
                  if (cnt_hit) begin
                     state_d = ST_SYNC_PEND;
                  end
               end
            end
            ST_SYNC_PEND: begin
               if (packet_ack_i) begin
                  state_d   = ST_TRACING;
                  cnt_clear = 1'b1;
               end
            end
            default: begin
               state_d   = ST_IDLE;
               cnt_clear = 1'b1;
            end
         endcase
      end
   end

   trdb_resync_counter #(
      .W(RESYNC_CNT_W)
   ) u_resync_counter (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (cnt_clear),
      .enable_i (cnt_en),
      .max_i    (resync_max_i),
      .cnt_o    (resync_cnt_o),
      .hit_o    (cnt_hit)
   );

endmodule

// File: tb/tb_trdb_qualif_sync.sv
// Bench for trdb_qualif_sync: a 16-bit and a 4-bit counter instance share
// stimulus; a cycle model feeds an expected queue compared after each edge.
module tb_trdb_qualif_sync;
   import trdb_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        trace_en, nc_q, valid, ack;
   logic [15:0] rmax;
   logic [3:0]  rmax4;

   logic        q, pc, first, unq, req;
   logic [15:0] cnt;
   logic [1:0]  st;
   logic        q4, pc4, first4, unq4, req4;
   logic [3:0]  cnt4;
   logic [1:0]  st4;

   always #5 clk = ~clk;

   trdb_qualif_sync #(.RESYNC_CNT_W(16)) dut (
      .clk_i(clk), .rst_ni(rst_n), .trace_enable_i(trace_en), .nc_qualified_i(nc_q),
      .valid_i(valid), .resync_max_i(rmax), .packet_ack_i(ack),
      .qualified_o(q), .pc_qualified_o(pc), .first_qualified_o(first), .unqualified_o(unq),
      .resync_req_o(req), .resync_cnt_o(cnt), .state_o(st)
   );

   trdb_qualif_sync #(.RESYNC_CNT_W(4)) dut4 (
      .clk_i(clk), .rst_ni(rst_n), .trace_enable_i(trace_en), .nc_qualified_i(nc_q),
      .valid_i(valid), .resync_max_i(rmax4), .packet_ack_i(ack),
      .qualified_o(q4), .pc_qualified_o(pc4), .first_qualified_o(first4), .unqualified_o(unq4),
      .resync_req_o(req4), .resync_cnt_o(cnt4), .state_o(st4)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [33:0] exp_q[$];

   logic m_q, m_pc;
   int   m_st[2];
   int   m_cnt[2];

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [33:0] dut_vec();
      return {q, pc, first, unq, req, cnt, st, q4, pc4, first4, unq4, req4, cnt4, st4};
   endfunction

   function automatic logic [33:0] model_vec();
      logic        f, u, r0, r1;
      logic [15:0] c0;
      logic [3:0]  c1;
      logic [1:0]  s0, s1;
      f  = m_q & ~m_pc;
      u  = ~m_q & m_pc;
      r0 = (m_st[0] == 2);
      r1 = (m_st[1] == 2);
      c0 = m_cnt[0][15:0];
      c1 = m_cnt[1][3:0];
      s0 = m_st[0][1:0];
      s1 = m_st[1][1:0];
      return {m_q, m_pc, f, u, r0, c0, s0, m_q, m_pc, f, u, r1, c1, s1};
   endfunction

   task automatic model_reset();
      m_q = 1'b0;
      m_pc = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_st[k]  = 0;
         m_cnt[k] = 0;
      end
   endtask

   // One clock of the reference behaviour, using the inputs currently driven.
   task automatic model_clock();
      int mx, sat;
      for (int k = 0; k < 2; k++) begin
         mx  = (k == 0) ? int'(rmax) : int'(rmax4);
         sat = (k == 0) ? 65535 : 15;
         if (!m_q) begin
            m_st[k] = 0;
            m_cnt[k] = 0;
         end else if (m_st[k] == 0) begin
            if (!m_pc) begin
               m_st[k] = 1;
               m_cnt[k] = 0;
            end
         end else if (m_st[k] == 1) begin
            if (valid) begin
               if (m_cnt[k] < sat) m_cnt[k] = m_cnt[k] + 1;
               if (mx != 0 && m_cnt[k] >= mx) m_st[k] = 2;
            end
         end else if (ack) begin
            m_st[k] = 1;
            m_cnt[k] = 0;
         end
      end
      m_pc = m_q;
      m_q  = nc_q & trace_en;
   endtask

   task automatic step(input string tag);
      model_clock();
      exp_q.push_back(model_vec());
      @(posedge clk);
      #1;
      check(tag, dut_vec(), exp_q.pop_front());
   endtask

   initial begin
      trace_en = 1'b1; nc_q = 1'b1; valid = 1'b0; ack = 1'b0;
      rmax = 16'd4; rmax4 = 4'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset", dut_vec(), 34'd0);

      // Start of trace after reset release
      rst_n = 1'b1;
      step("t1_q");
      check("t1_first", first, 1);
      step("t1_pc");
      check("t1_pc_q", pc, 1);
      check("t1_first_drop", first, 0);

      // Resync every 4 retirements, ack late
      valid = 1'b1;
      repeat (4) step("t2_count");
      check("t2_req", req, 1);
      check("t2_cnt", cnt, 16'd4);
      repeat (3) step("t2_hold");
      check("t2_req_hold", req, 1);
      check("t2_cnt_hold", cnt, 16'd4);
      ack = 1'b1;
      step("t2_ack");
      ack = 1'b0;
      check("t2_req_drop", req, 0);
      check("t2_cnt_clr", cnt, 16'd0);

      // Pending request killed by loss of qualification
      repeat (4) step("t4_count");
      check("t4_pend", req, 1);
      nc_q = 1'b0;
      valid = 1'b0;
      step("t4_q_drop");
      check("t4_unq", unq, 1);
      step("t4_idle");
      check("t4_req", req, 0);
      check("t4_cnt", cnt, 16'd0);
      check("t4_state", st, IDLE);
      ack = 1'b1;
      step("t4_late_ack");
      ack = 1'b0;
      check("t4_late_ack_req", req, 0);

      // Resync disabled: long run, and 4-bit counter saturation
      nc_q = 1'b1;
      rmax = 16'd0;
      step("t3_q");
      step("t3_trace");
      valid = 1'b1;
      for (int i = 1; i <= 1000; i++) begin
         step("t3_run");
         if (i == 20) check("t5_sat", cnt4, 4'd15);
      end
      check("t3_cnt", cnt, 16'd1000);
      check("t3_no_req", req, 0);
      check("t5_sat_end", cnt4, 4'd15);

      // Lowered period below count, then async reset mid-pending
      rmax = 16'd2;
      step("t6_pend");
      check("t6_req", req, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async", dut_vec(), 34'd0);
      model_reset();
      valid = 1'b0;
      @(posedge clk);
      #1;
      check("t6_held", dut_vec(), 34'd0);
      rst_n = 1'b1;

      // trace_enable low forces unqualified
      step("t6_q");
      step("t6_trace");
      trace_en = 1'b0;
      step("t6_en_off");
      check("t6_en_q", q, 0);
      step("t6_unq_end");
      trace_en = 1'b1;

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         nc_q     = ($urandom_range(0, 9) != 0);
         trace_en = ($urandom_range(0, 19) != 0);
         valid    = $urandom_range(0, 1);
         ack      = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) begin
            rmax  = 16'($urandom_range(0, 6));
            rmax4 = 4'($urandom_range(0, 5));
         end
         step("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
